xy_router_sync: RTL and testbench

XY_ROUTER_SYNC -- requirements
Module: xy_router_sync

---
 rtl/xy_router_sync_if.sv | 11 +
 rtl/xy_router_sync.sv | 95 +++++++++
 tb/tb_xy_router_sync.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/xy_router_sync_if.sv
// xy_router_sync_if: five-port valid/ready flit bundle between a router and its neighbours.
interface xy_router_sync_if #(parameter int N = 32);
  logic [4:0]        in_valid;
  logic [4:0]        in_ready;
  logic [4:0][N-1:0] in_data;
  logic [4:0]        out_valid;
  logic [4:0]        out_ready;
  logic [4:0][N-1:0] out_data;
  modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data);
  modport slave (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data);
endinterface

// File: rtl/xy_router_sync.sv
// xy_router_sync: 5-port XY mesh router, per-input FIFOs, round-robin output arbiters, registered outputs.
module xy_router_sync #(
  parameter int N = 32,
  parameter int XW = 2,
  parameter int YW = 2,
  parameter int SRCX = 0,
  parameter int SRCY = 0,
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic rst,
  xy_router_sync_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  logic [N-1:0] mem [5][DEPTH];
  logic [AW-1:0] rp [5];
  logic [AW-1:0] wp [5];
  logic [AW:0] cnt [5];
  logic [2:0] dir [5];
  logic [2:0] p [5];
  logic [2:0] g [5];
  logic [4:0] gv, ld, pop, push, rdy, ov;
  logic [4:0][N-1:0] od;
  assign bus.in_ready = rdy;
  assign bus.out_valid = ov;
  assign bus.out_data = od;
  assign push = bus.in_valid & rdy;
  always_comb begin
    logic [N-1:0] hd;
    logic [XW-1:0] hx;
    logic [YW-1:0] hy;
    hd = '0;
    hx = '0;
    hy = '0;
    for (int i = 0; i < 5; i++) begin
      rdy[i] = cnt[i] != (AW+1)'(DEPTH);
      hd = mem[i][rp[i]];
      hx = hd[N-1 -: XW];
      hy = hd[N-XW-1 -: YW];
      dir[i] = hx > XW'(SRCX) ? 3'd2 : hx < XW'(SRCX) ? 3'd4 :
               hy > YW'(SRCY) ? 3'd1 : hy < YW'(SRCY) ? 3'd3 : 3'd0;
    end
  end
  // Each output scans inputs from its pointer with wrap; an input routes to one output, so pops never collide.
  always_comb begin
    logic [3:0] s;
    logic [2:0] idx;
    s = '0;
    idx = '0;
    pop = '0;
    for (int o = 0; o < 5; o++) begin
      gv[o] = 1'b0;
      g[o] = '0;
      for (int k = 0; k < 5; k++) begin
        s = {1'b0, p[o]} + 4'(k);
        idx = s >= 4'd5 ? 3'(s - 4'd5) : 3'(s);
        if (!gv[o] && cnt[idx] != '0 && dir[idx] == 3'(o)) begin
          gv[o] = 1'b1;
          g[o] = idx;
        end
      end
      ld[o] = gv[o] && (!ov[o] || bus.out_ready[o]);
      for (int i = 0; i < 5; i++)
        if (ld[o] && g[o] == 3'(i)) pop[i] = 1'b1;
    end
  end
  always_ff @(posedge clk)
    for (int i = 0; i < 5; i++)
      if (push[i]) mem[i][wp[i]] <= bus.in_data[i];
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 5; i++) begin
        rp[i] <= '0;
        wp[i] <= '0;
        cnt[i] <= '0;
        p[i] <= '0;
      end
      ov <= '0;
      od <= '0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (push[i]) wp[i] <= wp[i] + 1'b1;
        if (pop[i]) rp[i] <= rp[i] + 1'b1;
        cnt[i] <= cnt[i] + (AW+1)'(push[i]) - (AW+1)'(pop[i]);
      end
      for (int o = 0; o < 5; o++) begin
        if (ld[o]) begin
          ov[o] <= 1'b1;
          od[o] <= mem[g[o]][rp[g[o]]];
          p[o] <= g[o] == 3'd4 ? 3'd0 : g[o] + 3'd1;
        end else if (bus.out_ready[o]) ov[o] <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_xy_router_sync.sv
// tb_xy_router_sync: directed checks plus scoreboarded random traffic for a router at (1,1).
module tb_xy_router_sync;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_err = 0;
  int acc;
  int seq [5];
  logic [4:0] stale;
  logic [15:0] sb [40][$];
  xy_router_sync_if #(.N(16)) bus ();
  xy_router_sync #(.N(16), .XW(2), .YW(2), .SRCX(1), .SRCY(1), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic int route(input logic [15:0] d);
    if (d[15:14] > 2'd1) return 2;
    if (d[15:14] < 2'd1) return 4;
    if (d[13:12] > 2'd1) return 1;
    if (d[13:12] < 2'd1) return 3;
    return 0;
  endfunction

  // Source port rides in data[10:8], so each emitted flit names its own scoreboard queue.
  task automatic observe();
    for (int o = 0; o < 5; o++)
      if (bus.out_valid[o] && bus.out_ready[o]) begin
        int k;
        k = int'(bus.out_data[o][10:8]) * 5 + o;
        chk("sb", 80'(bus.out_data[o]), sb[k].size() > 0 ? 80'(sb[k].pop_front()) : 80'hDEAD_0000);
      end
  endtask

  initial begin
    bus.in_valid = '0;
    bus.in_data = '0;
    bus.out_ready = 5'b11111;
    step();
    step();
    chk("rst_ov", 80'(bus.out_valid), 80'h0);
    chk("rst_od", 80'(bus.out_data), 80'h0);
    rst = 1'b0;
    chk("rdy_after_rst", 80'(bus.in_ready), 80'h1F);
    bus.in_valid = 5'b00001;
    bus.in_data[0] = 16'h9123;
    step();
    bus.in_valid = '0;
    chk("lat_early", 80'(bus.out_valid), 80'h0);
    step();
    chk("east_ov", 80'(bus.out_valid), 80'h04);
    chk("east_od", 80'(bus.out_data[2]), 80'h9123);
    step();
    chk("east_gone", 80'(bus.out_valid), 80'h0);
    bus.in_valid = 5'b00001;
    bus.in_data[0] = 16'h5A5A;
    step();
    bus.in_valid = '0;
    step();
    chk("loop_ov", 80'(bus.out_valid), 80'h01);
    chk("loop_od", 80'(bus.out_data[0]), 80'h5A5A);
    step();
    bus.in_valid = 5'b10010;
    bus.in_data[1] = 16'h5001;
    bus.in_data[4] = 16'h5004;
    step();
    bus.in_valid = '0;
    step();
    chk("rr_a0", 80'(bus.out_data[0]), 80'h5001);
    step();
    chk("rr_a1", 80'(bus.out_data[0]), 80'h5004);
    chk("rr_a1v", 80'(bus.out_valid), 80'h01);
    step();
    bus.in_valid = 5'b10010;
    bus.in_data[1] = 16'h5011;
    bus.in_data[4] = 16'h5014;
    step();
    bus.in_data[1] = 16'h5021;
    bus.in_data[4] = 16'h5024;
    step();
    bus.in_valid = '0;
    chk("rr_b0", 80'(bus.out_data[0]), 80'h5011);
    step();
    chk("rr_b1", 80'(bus.out_data[0]), 80'h5014);
    step();
    chk("rr_b2", 80'(bus.out_data[0]), 80'h5021);
    step();
    chk("rr_b3", 80'(bus.out_data[0]), 80'h5024);
    step();
    chk("rr_idle", 80'(bus.out_valid), 80'h0);
    bus.out_ready = 5'b11011;
    acc = 0;
    for (int c = 0; c < 12; c++) begin
      bus.in_valid = 5'b00001;
      bus.in_data[0] = 16'(16'h8001 + acc);
      #1;
      if (bus.in_ready[0]) acc++;
      step();
    end
    bus.in_valid = '0;
    chk("bp_count", 80'(acc), 80'd5);
    chk("bp_rdy", 80'(bus.in_ready[0]), 80'h0);
    chk("bp_hold", 80'(bus.out_data[2]), 80'h8001);
    bus.out_ready = 5'b11111;
    for (int k = 0; k < 5; k++) begin
      chk("bp_drain", 80'({bus.out_valid[2], bus.out_data[2]}), 80'({1'b1, 16'(16'h8001 + k)}));
      step();
    end
    chk("bp_empty", 80'(bus.out_valid), 80'h0);
    bus.out_ready = '0;
    bus.in_valid = 5'b00011;
    bus.in_data[0] = 16'h9AAA;
    bus.in_data[1] = 16'h5BBB;
    step();
    bus.in_data[0] = 16'h9AAB;
    bus.in_data[1] = 16'h5BBC;
    step();
    bus.in_valid = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_ov", 80'(bus.out_valid), 80'h0);
    chk("mid_rst_rdy", 80'(bus.in_ready), 80'h1F);
    bus.out_ready = 5'b11111;
    stale = '0;
    for (int c = 0; c < 8; c++) begin
      step();
      stale |= bus.out_valid;
    end
    chk("no_stale", 80'(stale), 80'h0);
    for (int i = 0; i < 5; i++) seq[i] = 0;
    for (int c = 0; c < 400; c++) begin
      bus.out_ready = 5'($urandom);
      for (int i = 0; i < 5; i++) begin
        bus.in_valid[i] = 1'($urandom);
        bus.in_data[i] = {4'($urandom), 1'b0, 3'(i), 8'(seq[i])};
      end
      #1;
      observe();
      for (int i = 0; i < 5; i++)
        if (bus.in_valid[i] && bus.in_ready[i]) begin
          sb[i * 5 + route(bus.in_data[i])].push_back(bus.in_data[i]);
          seq[i]++;
        end
      step();
    end
    bus.in_valid = '0;
    bus.out_ready = 5'b11111;
    for (int c = 0; c < 20; c++) begin
      #1;
      observe();
      step();
    end
    acc = 0;
    for (int k = 0; k < 40; k++) acc += sb[k].size();
    chk("sb_leftover", 80'(acc), 80'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
